// File: rtl/sync_mem.sv
// sync_mem: single-port synchronous RAM with a registered, read-first read port.
// One address bus serves both reads and writes. Reset is synchronous and
// active-low; it clears every word of storage and the read register.
module sync_mem #(
    parameter int ADDR_SIZE = 4,
    parameter int WORD_SIZE = 8
) (
    input  logic                 I_clk,
    input  logic                 I_rst_n,
    input  logic                 I_wen,
    input  logic [WORD_SIZE-1:0] I_wdata,
    input  logic [ADDR_SIZE-1:0] I_addr,
    output logic [WORD_SIZE-1:0] O_data
);

    localparam int DEPTH = 1 << ADDR_SIZE;

    logic [WORD_SIZE-1:0] mem [DEPTH];

    // Storage update: clear every word on reset, otherwise write when enabled.
    // A write presented on a reset edge is dropped.
    always_ff @(posedge I_clk) begin
        if (!I_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (I_wen) begin
            mem[I_addr] <= I_wdata;
        end
    end

    // Registered read every cycle; sampling the array before the write lands
    // gives read-first behaviour on a same-address collision.
    always_ff @(posedge I_clk) begin
        if (!I_rst_n) begin
            O_data <= '0;
        end else begin
            O_data <= mem[I_addr];
        end
    end

endmodule

// File: tb/tb_sync_mem.sv
// Scoreboard bench for sync_mem: the driver pushes the expected O_data for
// each edge into a queue, and a monitor pops and compares after each edge.
// A second instance covers ADDR_SIZE = 2, WORD_SIZE = 16.
module tb_sync_mem;

    typedef struct {
        int          which;
        logic        chk;
        logic [15:0] exp;
        string       name;
    } exp_t;

    logic        clk = 1'b0;

    logic        a_rst_n = 1'b0;
    logic        a_wen = 1'b0;
    logic [7:0]  a_wdata = '0;
    logic [3:0]  a_addr = '0;
    logic [7:0]  a_data;

    logic        b_rst_n = 1'b0;
    logic        b_wen = 1'b0;
    logic [15:0] b_wdata = '0;
    logic [1:0]  b_addr = '0;
    logic [15:0] b_data;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_pass = 0;

    sync_mem #(.ADDR_SIZE(4), .WORD_SIZE(8)) dut_a (
        .I_clk   (clk),
        .I_rst_n (a_rst_n),
        .I_wen   (a_wen),
        .I_wdata (a_wdata),
        .I_addr  (a_addr),
        .O_data  (a_data)
    );

    sync_mem #(.ADDR_SIZE(2), .WORD_SIZE(16)) dut_b (
        .I_clk   (clk),
        .I_rst_n (b_rst_n),
        .I_wen   (b_wen),
        .I_wdata (b_wdata),
        .I_addr  (b_addr),
        .O_data  (b_data)
    );

    always #5 clk = ~clk;

    // Drive one edge's worth of stimulus and queue the O_data expected after it.
    task automatic step(input int which, input logic rst_n, input logic wen,
                        input int addr, input logic [15:0] wdata,
                        input logic chk, input logic [15:0] exp, input string name);
        exp_t e;
        @(negedge clk);
        if (which == 0) begin
            a_rst_n = rst_n;
            a_wen   = wen;
            a_addr  = addr[3:0];
            a_wdata = wdata[7:0];
            b_wen   = 1'b0;
        end else begin
            b_rst_n = rst_n;
            b_wen   = wen;
            b_addr  = addr[1:0];
            b_wdata = wdata;
            a_wen   = 1'b0;
        end
        e.which = which;
        e.chk   = chk;
        e.exp   = exp;
        e.name  = name;
        sb.push_back(e);
    endtask

    // Monitor: after every edge, compare the selected output against the queue.
    always @(posedge clk) begin
        exp_t        e;
        logic [15:0] act;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            act = (e.which == 0) ? {8'h00, a_data} : b_data;
            if (e.chk) begin
                n_checks++;
                if (act === e.exp) begin
                    n_pass++;
                end else begin
                    $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, act, e.exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset both instances for two edges
        b_rst_n = 1'b0;
        step(0, 1'b0, 1'b0, 0, 16'h0, 1'b1, 16'h0, "reset_out");
        step(0, 1'b0, 1'b0, 0, 16'h0, 1'b1, 16'h0, "reset_out");

        // Readback after reset: all zero
        for (int i = 0; i < 16; i++)
            step(0, 1'b1, 1'b0, i, 16'h0, 1'b1, 16'h0, "reset_readback");

        // Sequential writes: data i+1 at address i; reads during writes see old 0
        for (int i = 0; i < 10; i++)
            step(0, 1'b1, 1'b1, i, 16'(i + 1), 1'b1, 16'h0, "write_readfirst");

        // Read addresses 0..19 (wraps 0..15, 0..3)
        for (int i = 0; i < 20; i++) begin
            int a;
            a = i % 16;
            step(0, 1'b1, 1'b0, a, 16'h0, 1'b1, (a < 10) ? 16'(a + 1) : 16'h0, "seq_read");
        end

        // Write-enable gating at address 3 (currently holds 4)
        step(0, 1'b1, 1'b1, 3, 16'h00AA, 1'b1, 16'h0004, "wen_write");
        step(0, 1'b1, 1'b0, 3, 16'h0055, 1'b1, 16'h00AA, "wen_gated");
        step(0, 1'b1, 1'b0, 3, 16'h0000, 1'b1, 16'h00AA, "wen_hold");

        // Read-first collision at address 5 (currently holds 6)
        step(0, 1'b1, 1'b1, 5, 16'h0011, 1'b1, 16'h0006, "coll_setup");
        step(0, 1'b1, 1'b1, 5, 16'h0022, 1'b1, 16'h0011, "coll_old");
        step(0, 1'b1, 1'b0, 5, 16'h0000, 1'b1, 16'h0022, "coll_new");

        // Fill 0..3 with 0x0F (outputs show the previous contents)
        step(0, 1'b1, 1'b1, 0, 16'h000F, 1'b1, 16'h0001, "fill");
        step(0, 1'b1, 1'b1, 1, 16'h000F, 1'b1, 16'h0002, "fill");
        step(0, 1'b1, 1'b1, 2, 16'h000F, 1'b1, 16'h0003, "fill");
        step(0, 1'b1, 1'b1, 3, 16'h000F, 1'b1, 16'h00AA, "fill");
        step(0, 1'b1, 1'b0, 2, 16'h0000, 1'b1, 16'h000F, "fill_check");

        // Reset with a pending write of 0xFF to address 2
        step(0, 1'b0, 1'b1, 2, 16'h00FF, 1'b1, 16'h0000, "midreset_out");
        for (int i = 0; i < 4; i++)
            step(0, 1'b1, 1'b0, i, 16'h0, 1'b1, 16'h0, "post_reset_read");
        step(0, 1'b1, 1'b0, 5, 16'h0, 1'b1, 16'h0, "post_reset_read5");

        // Second instance: ADDR_SIZE = 2, WORD_SIZE = 16
        step(1, 1'b1, 1'b1, 3, 16'hBEEF, 1'b1, 16'h0000, "p_write");
        step(1, 1'b1, 1'b0, 3, 16'h0000, 1'b1, 16'hBEEF, "p_read3");
        for (int i = 0; i < 3; i++)
            step(1, 1'b1, 1'b0, i, 16'h0000, 1'b1, 16'h0000, "p_read_other");
        step(1, 1'b1, 1'b0, 3, 16'h0000, 1'b1, 16'hBEEF, "p_read3_again");

        // Let the monitor drain the queue
        repeat (3) @(negedge clk);
        n_checks++;
        if (sb.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
